// File: rtl/usb_data_buffer.sv
// 64-byte endpoint FIFO shared by the AHB slave registers and the USB RX/TX packet engines.
// Define DATA_BUFFER_ERR_EN to add the sticky overflow/underflow flags.
module usb_data_buffer #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clear,
    input  logic              store_tx_data,
    input  logic [7:0]        tx_data,
    input  logic              get_rx_data,
    output logic [7:0]        rx_data,
    input  logic              store_rx_packet_data,
    input  logic [7:0]        rx_packet_data,
    input  logic              get_tx_packet_data,
    output logic [7:0]        tx_packet_data,
    output logic [ADDR_W:0]   buffer_occupancy
`ifdef DATA_BUFFER_ERR_EN
    ,
    output logic              overflow,
    output logic              underflow
`endif
);

    localparam logic [ADDR_W:0] FullCount = (ADDR_W + 1)'(DEPTH);

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W:0]   count_q, count_d;

    logic       wr, rd, empty, full, do_wr, do_rd;
    logic [7:0] wr_byte, head;

    always_comb begin
        wr      = store_rx_packet_data | store_tx_data;
        rd      = get_rx_data | get_tx_packet_data;
        // The USB RX engine wins a write collision; the AHB byte is lost.
        wr_byte = store_rx_packet_data ? rx_packet_data : tx_data;
        empty   = (count_q == '0);
        full    = (count_q == FullCount);
        do_rd   = rd & ~empty;
        // A simultaneous pop frees the slot, so a full buffer still accepts the write.
        do_wr   = wr & (~full | do_rd);

        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (clear) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            wptr_d  = wptr_q + ADDR_W'(do_wr);
            rptr_d  = rptr_q + ADDR_W'(do_rd);
            count_d = count_q + (ADDR_W + 1)'(do_wr) - (ADDR_W + 1)'(do_rd);
        end
    end

    always_ff @(posedge clk, negedge n_rst) begin
        if (!n_rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!clear && do_wr) begin
            mem_q[wptr_q] <= wr_byte;
        end
    end

    always_comb begin
        head             = empty ? 8'h00 : mem_q[rptr_q];
        rx_data          = head;
        tx_packet_data   = head;
        buffer_occupancy = count_q;
    end

`ifdef DATA_BUFFER_ERR_EN
    logic overflow_q, overflow_d, underflow_q, underflow_d;

    always_comb begin
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        if (!clear) begin
            overflow_d  = overflow_q | (wr & ~do_wr) | (store_rx_packet_data & store_tx_data);
            underflow_d = underflow_q | (rd & empty);
        end
    end

    always_ff @(posedge clk, negedge n_rst) begin
        if (!n_rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_usb_data_buffer.sv
// Directed bench for usb_data_buffer; flag checks are compiled in with DATA_BUFFER_ERR_EN.
module tb_usb_data_buffer;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       clear;
    logic       store_tx_data;
    logic [7:0] tx_data;
    logic       get_rx_data;
    logic [7:0] rx_data;
    logic       store_rx_packet_data;
    logic [7:0] rx_packet_data;
    logic       get_tx_packet_data;
    logic [7:0] tx_packet_data;
    logic [6:0] buffer_occupancy;
`ifdef DATA_BUFFER_ERR_EN
    logic       overflow;
    logic       underflow;
`endif

    int n_checks = 0;
    int n_passed = 0;

    always #5 clk = ~clk;

    usb_data_buffer dut (
        .clk                  (clk),
        .n_rst                (n_rst),
        .clear                (clear),
        .store_tx_data        (store_tx_data),
        .tx_data              (tx_data),
        .get_rx_data          (get_rx_data),
        .rx_data              (rx_data),
        .store_rx_packet_data (store_rx_packet_data),
        .rx_packet_data       (rx_packet_data),
        .get_tx_packet_data   (get_tx_packet_data),
        .tx_packet_data       (tx_packet_data),
        .buffer_occupancy     (buffer_occupancy)
`ifdef DATA_BUFFER_ERR_EN
        ,
        .overflow             (overflow),
        .underflow            (underflow)
`endif
    );

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_checks++;
        if (observed === expected) n_passed++;
        else $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clear                = 1'b0;
        store_tx_data        = 1'b0;
        get_rx_data          = 1'b0;
        store_rx_packet_data = 1'b0;
        get_tx_packet_data   = 1'b0;
    endtask

    task automatic do_clear();
        idle();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic fill_rx(input logic [7:0] base);
        store_rx_packet_data = 1'b1;
        for (int i = 0; i < 64; i++) begin
            rx_packet_data = base + 8'(i);
            tick();
        end
        store_rx_packet_data = 1'b0;
    endtask

    initial begin
        idle();
        tx_data        = 8'h00;
        rx_packet_data = 8'h00;
        n_rst          = 1'b0;
        #12;
        n_rst = 1'b1;
        tick();

        // Reset state
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_tx_packet_data", 32'(tx_packet_data), 32'h00);
        check("rst_occupancy", 32'(buffer_occupancy), 32'd0);
`ifdef DATA_BUFFER_ERR_EN
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
`endif

        // Three AHB writes, three TX pops
        store_tx_data = 1'b1;
        tx_data = 8'hA1; tick();
        tx_data = 8'hB2; tick();
        tx_data = 8'hC3; tick();
        store_tx_data = 1'b0;
        check("ahb_occ3", 32'(buffer_occupancy), 32'd3);
        get_tx_packet_data = 1'b1;
        check("tx_pop0", 32'(tx_packet_data), 32'hA1); tick();
        check("tx_pop1", 32'(tx_packet_data), 32'hB2); tick();
        check("tx_pop2", 32'(tx_packet_data), 32'hC3); tick();
        get_tx_packet_data = 1'b0;
        check("tx_occ0", 32'(buffer_occupancy), 32'd0);
        check("tx_empty_head", 32'(tx_packet_data), 32'h00);

        // Fill 64 RX bytes starting at pointer 3, so both pointers wrap
        fill_rx(8'h00);
        check("fill_occ64", 32'(buffer_occupancy), 32'd64);
        store_rx_packet_data = 1'b1;
        rx_packet_data = 8'hFF;
        tick();
        store_rx_packet_data = 1'b0;
        check("full_wr_occ", 32'(buffer_occupancy), 32'd64);
        check("full_wr_head", 32'(rx_data), 32'h00);
`ifdef DATA_BUFFER_ERR_EN
        check("full_wr_overflow", 32'(overflow), 32'd1);
`endif
        get_rx_data = 1'b1;
        for (int i = 0; i < 64; i++) begin
            check($sformatf("rx_pop%0d", i), 32'(rx_data), 32'(i));
            tick();
        end
        get_rx_data = 1'b0;
        check("drain_occ0", 32'(buffer_occupancy), 32'd0);
`ifdef DATA_BUFFER_ERR_EN
        check("overflow_sticky", 32'(overflow), 32'd1);
        do_clear();
        check("overflow_cleared", 32'(overflow), 32'd0);
`endif

        // Write collision on empty buffer
        store_rx_packet_data = 1'b1; rx_packet_data = 8'h55;
        store_tx_data        = 1'b1; tx_data        = 8'h66;
        tick();
        idle();
        check("collide_occ", 32'(buffer_occupancy), 32'd1);
        check("collide_head", 32'(rx_data), 32'h55);
`ifdef DATA_BUFFER_ERR_EN
        check("collide_overflow", 32'(overflow), 32'd1);
`endif
        do_clear();

        // Clear wins over a simultaneous write and read
        store_tx_data = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tx_data = 8'h10 + 8'(i);
            tick();
        end
        check("load10_occ", 32'(buffer_occupancy), 32'd10);
        clear = 1'b1; tx_data = 8'hEE; get_rx_data = 1'b1;
        tick();
        idle();
        check("clear_occ", 32'(buffer_occupancy), 32'd0);
        check("clear_head", 32'(rx_data), 32'h00);
`ifdef DATA_BUFFER_ERR_EN
        check("clear_overflow", 32'(overflow), 32'd0);
        check("clear_underflow", 32'(underflow), 32'd0);
`endif
        store_tx_data = 1'b1; tx_data = 8'h77;
        tick();
        idle();
        check("post_clear_occ", 32'(buffer_occupancy), 32'd1);
        check("post_clear_head", 32'(tx_packet_data), 32'h77);
        do_clear();

        // Full buffer with write and read together
        fill_rx(8'h80);
        check("full2_occ", 32'(buffer_occupancy), 32'd64);
        check("full2_head", 32'(rx_data), 32'h80);
        store_tx_data = 1'b1; tx_data = 8'hEE; get_tx_packet_data = 1'b1;
        tick();
        idle();
        check("full_wrrd_occ", 32'(buffer_occupancy), 32'd64);
        check("full_wrrd_head", 32'(rx_data), 32'h81);
`ifdef DATA_BUFFER_ERR_EN
        check("full_wrrd_overflow", 32'(overflow), 32'd0);
`endif
        get_rx_data = 1'b1;
        for (int i = 0; i < 63; i++) tick();
        get_rx_data = 1'b0;
        check("full_wrrd_tail", 32'(rx_data), 32'hEE);
        check("full_wrrd_tail_occ", 32'(buffer_occupancy), 32'd1);
        do_clear();

        // Empty buffer with write and read together
        store_rx_packet_data = 1'b1; rx_packet_data = 8'h42; get_rx_data = 1'b1;
        tick();
        idle();
        check("empty_wrrd_occ", 32'(buffer_occupancy), 32'd1);
        check("empty_wrrd_head", 32'(rx_data), 32'h42);
`ifdef DATA_BUFFER_ERR_EN
        check("empty_wrrd_underflow", 32'(underflow), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
